// File: rtl/deser_pkg.sv
// Shared types and constants for the 1-to-WIDTH serial deserializer.
// Optional feature macro used across the block: DESER_PARITY_EN.
package deser_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Bit counter width; leaves headroom for the optional parity beat.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/deser_if.sv
// Serial input and parallel output handshake bundle of the deserializer.
// par_err exists only when DESER_PARITY_EN is defined.
interface deser_if
    import deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             sin;
    logic             sin_valid;
    logic             sof;
    logic             sin_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             frame_err;
`ifdef DESER_PARITY_EN
    logic             par_err;

    modport slave (
        input  sin, sin_valid, sof, out_ready,
        output sin_ready, out, out_valid, frame_err, par_err
    );
    modport master (
        output sin, sin_valid, sof, out_ready,
        input  sin_ready, out, out_valid, frame_err, par_err
    );
`else
    modport slave (
        input  sin, sin_valid, sof, out_ready,
        output sin_ready, out, out_valid, frame_err
    );
    modport master (
        output sin, sin_valid, sof, out_ready,
        input  sin_ready, out, out_valid, frame_err
    );
`endif
endinterface

// File: rtl/deser_out_slot.sv
// Single-entry valid/ready output register: load, hold until accepted, drain.
module deser_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    // A load wins over a drain so back-to-back words keep valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/deser_1to8.sv
// Serial-to-parallel deserializer with framed input and registered output.
// Define DESER_PARITY_EN to add a trailing even-parity beat and par_err.
//
// state | meaning
// IDLE  | waiting for a start-of-frame beat
// SHIFT | collecting data bits
// PAR   | waiting for the parity beat (DESER_PARITY_EN only)
// WAIT  | word complete, output slot busy, serial input stalled
module deser_1to8
    import deser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic    clk,
    input logic    rst,
    deser_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] load_word, done_word;
    logic             frame_err_q, frame_err_d;
    logic             accept, slot_free, load, done;
`ifdef DESER_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             par_err_q, par_err_d;
    logic             done_bad;
`endif

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        if (MSB_FIRST) return {cur[WIDTH-2:0], b};
        return {b, cur[WIDTH-1:1]};
    endfunction

    assign bus.sin_ready = (state_q != WAIT);
    assign accept        = bus.sin_valid & bus.sin_ready;
    assign slot_free     = ~bus.out_valid | bus.out_ready;
    assign bus.frame_err = frame_err_q;
`ifdef DESER_PARITY_EN
    assign bus.par_err   = par_err_q;
`endif

    // Next-state, datapath and output-load decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        load        = 1'b0;
        load_word   = shreg_q;
        done        = 1'b0;
        done_word   = shreg_q;
`ifdef DESER_PARITY_EN
        par_bad_d   = par_bad_q;
        par_err_d   = 1'b0;
        done_bad    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept && bus.sof) begin
                    shreg_d = shift_in('0, bus.sin);
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    if (bus.sof) begin
                        frame_err_d = 1'b1;
                        shreg_d     = shift_in('0, bus.sin);
                        cnt_d       = CW'(1);
                    end else if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef DESER_PARITY_EN
                        shreg_d = shift_in(shreg_q, bus.sin);
                        cnt_d   = CW'(WIDTH);
                        state_d = PAR;
`else
                        done      = 1'b1;
                        done_word = shift_in(shreg_q, bus.sin);
`endif
                    end else begin
                        shreg_d = shift_in(shreg_q, bus.sin);
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            PAR: begin
`ifdef DESER_PARITY_EN
                if (accept) begin
                    if (bus.sof) begin
                        frame_err_d = 1'b1;
                        shreg_d     = shift_in('0, bus.sin);
                        cnt_d       = CW'(1);
                        state_d     = SHIFT;
                    end else begin
                        done      = 1'b1;
                        done_word = shreg_q;
                        done_bad  = bus.sin ^ (^shreg_q);
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            WAIT: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_word = shreg_q;
`ifdef DESER_PARITY_EN
                    par_err_d = par_bad_q;
`endif
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A finished word goes straight to the slot if it is free, else parks here.
        if (done) begin
            cnt_d = '0;
            if (slot_free) begin
                load      = 1'b1;
                load_word = done_word;
`ifdef DESER_PARITY_EN
                par_err_d = done_bad;
`endif
                state_d   = IDLE;
            end else begin
                shreg_d   = done_word;
`ifdef DESER_PARITY_EN
                par_bad_d = done_bad;
`endif
                state_d   = WAIT;
            end
        end
    end

    // State, counter, shift register and error pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef DESER_PARITY_EN
            par_bad_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
`ifdef DESER_PARITY_EN
            par_bad_q   <= par_bad_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    deser_out_slot #(.WIDTH(WIDTH)) u_out_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_word),
        .ready     (bus.out_ready),
        .data      (bus.out),
        .valid     (bus.out_valid)
    );

endmodule

// File: tb/tb_deser_1to8.sv
// Bench for deser_1to8: an MSB-first and an LSB-first instance share one
// stimulus stream; a frame-level reference model predicts every cycle.
// Honours DESER_PARITY_EN when defined.
module tb_deser_1to8;
    import deser_pkg::*;

    localparam int W = 8;
`ifdef DESER_PARITY_EN
    localparam int FRAME_LEN = W + 1;
`else
    localparam int FRAME_LEN = W;
`endif

    logic clk;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    deser_if #(.WIDTH(W)) bus_m ();
    deser_if #(.WIDTH(W)) bus_l ();

    assign bus_l.sin       = bus_m.sin;
    assign bus_l.sin_valid = bus_m.sin_valid;
    assign bus_l.sof       = bus_m.sof;
    assign bus_l.out_ready = bus_m.out_ready;

    deser_1to8 #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m.slave));
    deser_1to8 #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: partial frame as a bit list, one parked word, output slot.
    bit       m_bits[$];
    bit       m_held;
    bit [W-1:0] m_held_m, m_held_l;
    bit [W-1:0] m_out_m, m_out_l;
    bit       m_valid;
    bit       m_ferr;
`ifdef DESER_PARITY_EN
    bit       m_held_bad;
    bit       m_perr;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_held   = 1'b0;
        m_held_m = '0;
        m_held_l = '0;
        m_out_m  = '0;
        m_out_l  = '0;
        m_valid  = 1'b0;
        m_ferr   = 1'b0;
`ifdef DESER_PARITY_EN
        m_held_bad = 1'b0;
        m_perr     = 1'b0;
`endif
    endtask

    task automatic model_update(input bit acc, input bit s, input bit b, input bit r);
        bit         slot_free;
        bit         load;
        bit [W-1:0] wm, wl;
        int         ones;
        slot_free = !m_valid || r;
        load      = 1'b0;
        wm        = '0;
        wl        = '0;
        ones      = 0;
        m_ferr    = 1'b0;
`ifdef DESER_PARITY_EN
        m_perr    = 1'b0;
`endif
        if (m_held) begin
            if (slot_free) begin
                load   = 1'b1;
                wm     = m_held_m;
                wl     = m_held_l;
                m_held = 1'b0;
`ifdef DESER_PARITY_EN
                m_perr = m_held_bad;
`endif
            end
        end else if (acc) begin
            if (s) begin
                if (m_bits.size() > 0) m_ferr = 1'b1;
                m_bits.delete();
                m_bits.push_back(b);
            end else if (m_bits.size() > 0) begin
                m_bits.push_back(b);
            end
            if (m_bits.size() == FRAME_LEN) begin
                for (int i = 0; i < W; i++) begin
                    wm = wm * 2 + W'(m_bits[i]);
                    wl = wl | (W'(m_bits[i]) << i);
                end
                for (int i = 0; i < FRAME_LEN; i++) ones += int'(m_bits[i]);
                m_bits.delete();
                if (slot_free) begin
                    load = 1'b1;
`ifdef DESER_PARITY_EN
                    m_perr = (ones % 2) != 0;
`endif
                end else begin
                    m_held   = 1'b1;
                    m_held_m = wm;
                    m_held_l = wl;
`ifdef DESER_PARITY_EN
                    m_held_bad = (ones % 2) != 0;
`endif
                end
            end
        end
        if (load) begin
            m_out_m = wm;
            m_out_l = wl;
            m_valid = 1'b1;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk("sin_ready_m", 32'(bus_m.sin_ready), 32'(!m_held));
        chk("sin_ready_l", 32'(bus_l.sin_ready), 32'(!m_held));
        chk("out_valid_m", 32'(bus_m.out_valid), 32'(m_valid));
        chk("out_valid_l", 32'(bus_l.out_valid), 32'(m_valid));
        chk("out_m", 32'(bus_m.out), 32'(m_out_m));
        chk("out_l", 32'(bus_l.out), 32'(m_out_l));
        chk("frame_err_m", 32'(bus_m.frame_err), 32'(m_ferr));
        chk("frame_err_l", 32'(bus_l.frame_err), 32'(m_ferr));
`ifdef DESER_PARITY_EN
        chk("par_err_m", 32'(bus_m.par_err), 32'(m_perr));
        chk("par_err_l", 32'(bus_l.par_err), 32'(m_perr));
`endif
    endtask

    // One clock: check the state left by the previous edge, then drive the next beat.
    task automatic step(input bit v, input bit s, input bit b, input bit r);
        @(negedge clk);
        check_outputs();
        bus_m.sin_valid = v;
        bus_m.sof       = s;
        bus_m.sin       = b;
        bus_m.out_ready = r;
        model_update(v && !m_held, s, b, r);
    endtask

    task automatic send_frame(input bit [W-1:0] data, input bit r, input bit flip);
        for (int i = W - 1; i >= 0; i--) step(1'b1, i == W - 1, data[i], r);
`ifdef DESER_PARITY_EN
        step(1'b1, 1'b0, (^data) ^ flip, r);
`else
        if (flip) step(1'b0, 1'b0, 1'b0, r);
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
        bus_m.sin_valid = 1'b0;
        bus_m.sof       = 1'b0;
        bus_m.sin       = 1'b0;
        bus_m.out_ready = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", 32'(bus_m.out_valid), 32'(0));
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        model_update(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit v, s, b, r;
        rst = 1'b1;
        bus_m.sin_valid = 1'b0;
        bus_m.sof       = 1'b0;
        bus_m.sin       = 1'b0;
        bus_m.out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        model_update(1'b0, 1'b0, 1'b0, 1'b0);

        // Basic frame 1,0,1,1,0,0,1,0
        send_frame(8'hB2, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic_msb", 32'(bus_m.out), 32'hB2);
        chk("basic_lsb", 32'(bus_l.out), 32'h4D);
        chk("basic_valid", 32'(bus_m.out_valid), 32'(1));

        // Back-to-back frames with no gap
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hE1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure: two frames against a stalled consumer
        send_frame(8'hA7, 1'b0, 1'b0);
        send_frame(8'h19, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_ready", 32'(bus_m.sin_ready), 32'(0));
        chk("bp_held", 32'(bus_m.out), 32'hA7);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_second", 32'(bus_m.out), 32'h19);
        chk("bp_ready_back", 32'(bus_m.sin_ready), 32'(1));
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Truncated frame then a full 0xFF frame
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("trunc_word", 32'(bus_m.out), 32'hFF);

        // Reset mid-frame while a word is still undelivered
        send_frame(8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'(i), 1'b0);
        apply_reset();
        send_frame(8'h5A, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_word", 32'(bus_m.out), 32'h5A);

`ifdef DESER_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("par_bad", 32'(bus_m.par_err), 32'(1));
        chk("par_bad_word", 32'(bus_m.out), 32'h03);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("par_pulse_end", 32'(bus_m.par_err), 32'(0));
        send_frame(8'h03, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("par_good", 32'(bus_m.par_err), 32'(0));
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            v = $urandom_range(0, 9) < 7;
            if (m_bits.size() == 0) s = $urandom_range(0, 9) < 8;
            else                    s = $urandom_range(0, 29) == 0;
            b = 1'($urandom);
            r = (n % 200) < 170 ? ($urandom_range(0, 3) != 0) : 1'b0;
            step(v, s, b, r);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/deser_1to8.md
# deser_1to8

Serial-to-parallel deserializer: collects a framed serial bit stream, one bit per accepted beat, into a WIDTH-bit word. It presents the word on a registered parallel output with a valid/ready handshake. It is the fan-out counterpart of the team's 8-input registered reduction netlist and sits between a single-bit serial source and WIDTH-wide flop-bank consumers in the STA test designs.

## Interface

- WIDTH, 8, data bits per frame (legal range 2..32).
- MSB_FIRST, 1: first serial bit lands in OUT[WIDTH-1]. 0: first serial bit lands in OUT[0].

- CLK  in  1  rising-edge clock, sole clock.
- RST  in  1  asynchronous, active-high reset.
- SIN  in  1  serial data bit.
- SIN_VALID  in  1  SIN/SOF qualifier.
- SOF  in  1  start-of-frame flag, sampled with SIN_VALID.
- SIN_READY  out  1  beat acceptance; a beat is accepted when SIN_VALID & SIN_READY.
- OUT  out  WIDTH  assembled word, registered.
- OUT_VALID  out  1  OUT holds an undelivered word.
- OUT_READY  in  1  consumer accepts OUT.
- FRAME_ERR  out  1  one-cycle pulse on a truncated frame.
- PAR_ERR  out  1  one-cycle parity-error pulse (present only with DESER_PARITY_EN).

## Operation

- States: IDLE, SHIFT, PAR (macro only), WAIT.
- **IDLE**
  - Accepted beat with SOF=1: stores the bit as frame bit 0, cnt=1, moves to SHIFT.
  - Accepted beat with SOF=0: discarded, no error.
- **SHIFT**
  - Each accepted beat stores the next bit and increments cnt.
  - Accepted beat with SOF=1: pulses FRAME_ERR, drops the partial word, and restarts at bit 0 with cnt=1.
  - Accepting bit WIDTH-1 completes the word.
- **Word completion**
  - Output slot free (OUT_VALID=0, or OUT_VALID&OUT_READY this cycle): the word moves to OUT at the same edge and the state returns to IDLE.
  - Otherwise: the state moves to WAIT.
- **WAIT**
  - SIN_READY=0; the word is held in the shift register.
  - On the cycle OUT_VALID&OUT_READY holds, the word transfers to OUT and the state moves to IDLE.
- SIN_READY=1 in every state except WAIT. It is a decode of the state register only, with no combinational path from OUT_READY.
- OUT and OUT_VALID are stable while OUT_VALID=1 and OUT_READY=0. OUT_VALID clears on handshake unless a new word loads in the same cycle.
- cnt width is clog2(WIDTH+2). cnt never exceeds WIDTH (WIDTH+1 with parity).

## Timing

- Reset values: SIN_READY=1, OUT=0, OUT_VALID=0, FRAME_ERR=0, PAR_ERR=0, state IDLE, cnt=0.
- Latency: last bit accepted at edge k gives OUT_VALID=1 after edge k, provided the slot is free.
- Throughput: one word per WIDTH accepted beats, back-to-back. SOF of the next frame may arrive the cycle after the last bit.
- RST asserted mid-frame or in WAIT: the partial or held word is lost, and OUT_VALID drops immediately (asynchronously).
- FRAME_ERR asserts the cycle after the offending beat is accepted.

## Configuration

- DESER_PARITY_EN defined:
  - The frame is WIDTH+1 bits; the final beat is an even-parity bit over the data bits.
  - State PAR is entered after data bit WIDTH-1.
  - The word is delivered regardless of parity.
  - PAR_ERR pulses in the same cycle OUT_VALID rises for a bad word. If the word goes through WAIT, PAR_ERR pulses when it loads into OUT.
- DESER_PARITY_EN undefined: the frame is WIDTH bits, PAR does not exist, and the PAR_ERR port is absent.

## Structure

- deser_pkg: state enum typedef (IDLE, SHIFT, PAR, WAIT), a count-width function, and the default WIDTH constant.
- One sub-module: deser_out_slot, a WIDTH-wide valid/ready output register (load, hold, drain).
- The FSM, counter and shift register stay in the top module.

## Test plan

- **Basic, MSB_FIRST=1, WIDTH=8:** SOF on the first of bits 1,0,1,1,0,0,1,0 with OUT_READY=1 -> OUT=8'hB2, OUT_VALID high one cycle after the 8th bit.
- **MSB_FIRST=0:** same bit stream -> OUT=8'h4D.
- **Backpressure:** OUT_READY=0 and two frames sent -> first word held, SIN_READY=0 after the second word completes. OUT_READY=1 for one cycle -> second word appears and SIN_READY returns to 1.
- **Truncated frame:** SOF, 3 bits, then SOF plus 8 bits 0xFF -> FRAME_ERR single pulse, OUT=8'hFF, no word from the truncated frame.
- **Reset mid-frame:** RST after 5 bits -> outputs at reset values. A new full frame 0x5A then decodes correctly.
- **Parity (macro on):** data 0x03 with parity 1 -> OUT=8'h03, PAR_ERR=1 for exactly one cycle. Parity 0 -> PAR_ERR stays 0.
